conv2_pool_relu: RTL and testbench



---
 rtl/cnn_pkg.sv | 21 ++
 rtl/pool_max2.sv | 15 +
 rtl/conv2_pool_relu.sv | 145 ++++++++++++++
 tb/tb_conv2_pool_relu.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN definitions: conv2 feature-map geometry, datapath widths, activation bounds.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cnn_pkg;

    // conv2 output feature map geometry
    localparam int CONV2_IMG_W = 8;
    localparam int CONV2_IMG_H = 8;

    // conv2 sum width and post-activation width
    localparam int CONV2_SUM_W = 14;
    localparam int ACT_W       = 12;

    // Saturation bounds of a signed ACT_W value
    localparam int ACT_MAX = (2 ** (ACT_W - 1)) - 1;
    localparam int ACT_MIN = -(2 ** (ACT_W - 1));

    typedef logic signed [CONV2_SUM_W-1:0] conv2_sum_t;
    typedef logic signed [ACT_W-1:0]       act_t;

endpackage

// File: rtl/pool_max2.sv
// Signed two-input maximum used by the 2x2 max-pool datapath.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i  signed W-bit operands; max_o  the larger of the two.
module pool_max2 #(
    parameter int W = 12
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] max_o
);

    assign max_o = (a_i > b_i) ? a_i : b_i;

endmodule

// File: rtl/conv2_pool_relu.sv
// Per-channel conv2 back end: bias add, optional ReLU, saturate to OUT_W, 2x2/stride-2 max-pool.
// Latency: pooled pixel registered 1 cycle after the bottom-right pixel of its 2x2 window.
// Backpressure: none; the consumer must take every out_valid strobe.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid, in_data   one raster pixel per strobe, signed IN_W
//   out_valid, out_data pooled pixel strobe and signed OUT_W value (held between strobes)
//   frame_done          pulses together with the last pooled pixel of a frame
// Build option: define CONV2_POOL_RELU_EN to clamp negative bias-added sums to 0.
module conv2_pool_relu
    import cnn_pkg::*;
#(
    parameter int                     IN_W  = CONV2_SUM_W,
    parameter int                     OUT_W = ACT_W,
    parameter int                     IMG_W = CONV2_IMG_W,  // even, >= 4
    parameter int                     IMG_H = CONV2_IMG_H,  // even
    parameter logic signed [IN_W-1:0] BIAS  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int BW = CW - 1;
    localparam int BD = IMG_W / 2;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    localparam logic signed [IN_W:0] SAT_MAX = (IN_W + 1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;   // -(2^(OUT_W-1))

    // ---------------- front end: bias, ReLU, saturate ----------------
    logic signed [IN_W:0]    sum_s;
    logic signed [IN_W:0]    act_s;
    logic signed [OUT_W-1:0] px_sat;

    // One extra bit so the bias add can never wrap
    assign sum_s = {in_data[IN_W-1], in_data} + {BIAS[IN_W-1], BIAS};

`ifdef CONV2_POOL_RELU_EN
    assign act_s = sum_s[IN_W] ? '0 : sum_s;
`else
    assign act_s = sum_s;
`endif

    always_comb begin
        px_sat = act_s[OUT_W-1:0];
        if (act_s > SAT_MAX) begin
            px_sat = SAT_MAX[OUT_W-1:0];
        end else if (act_s < SAT_MIN) begin
            px_sat = SAT_MIN[OUT_W-1:0];
        end
    end

    // ---------------- state ----------------
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic signed [OUT_W-1:0] hold_q;
    logic signed [OUT_W-1:0] buf_q [BD];
    logic                    out_valid_q, out_valid_d;
    logic                    frame_done_q, frame_done_d;
    logic signed [OUT_W-1:0] out_data_q;

    logic                    col_last, row_last;
    logic [BW-1:0]           buf_idx;
    logic signed [OUT_W-1:0] pair_max;
    logic signed [OUT_W-1:0] win_max;

    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);
    assign buf_idx  = col_q[CW-1:1];

    // Horizontal pair max (held even-column pixel vs current odd-column pixel)
    pool_max2 #(.W(OUT_W)) u_pair_max (
        .a_i   (hold_q),
        .b_i   (px_sat),
        .max_o (pair_max)
    );

    // Window max: pair max of the upper row (buffered) vs pair max of this row
    pool_max2 #(.W(OUT_W)) u_row_max (
        .a_i   (buf_q[buf_idx]),
        .b_i   (pair_max),
        .max_o (win_max)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_valid) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // A window completes on every odd-row, odd-column pixel
    assign out_valid_d  = in_valid & row_q[0] & col_q[0];
    assign frame_done_d = out_valid_d & col_last & row_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_data_q   <= '0;
            for (int i = 0; i < BD; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            if (in_valid) begin
                if (!col_q[0]) begin
                    hold_q <= px_sat;
                end else if (!row_q[0]) begin
                    buf_q[buf_idx] <= pair_max;
                end
            end
            if (out_valid_d) begin
                out_data_q <= win_max;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv2_pool_relu.sv
// Bench for conv2_pool_relu: two instances (BIAS=0 and BIAS=+100) fed the same pixel stream.
// Expected pooled outputs come from a frame-level reference model and are queued per instance.
// Monitors pop and compare value, frame_done and arrival cycle whenever out_valid is seen.
module tb_conv2_pool_relu;

    localparam int IN_W   = 14;
    localparam int OUT_W  = 12;
    localparam int W      = 8;
    localparam int H      = 8;
    localparam int NPIX   = W * H;
    localparam int BIAS_A = 0;
    localparam int BIAS_B = 100;

    typedef struct {
        int     val;
        bit     fd;
        longint cyc;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_data;
    logic                    ov_a, fd_a, ov_b, fd_b;
    logic signed [OUT_W-1:0] od_a, od_b;

    exp_t   q_a[$];
    exp_t   q_b[$];
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;

    conv2_pool_relu #(.IN_W(IN_W), .OUT_W(OUT_W), .IMG_W(W), .IMG_H(H),
                      .BIAS(14'(BIAS_A))) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov_a), .out_data(od_a), .frame_done(fd_a)
    );

    conv2_pool_relu #(.IN_W(IN_W), .OUT_W(OUT_W), .IMG_W(W), .IMG_H(H),
                      .BIAS(14'(BIAS_B))) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov_b), .out_data(od_b), .frame_done(fd_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: bias, optional ReLU, clamp to the signed OUT_W range
    function automatic int xform(input int p, input int bias);
        int s;
        s = p + bias;
`ifdef CONV2_POOL_RELU_EN
        if (s < 0) s = 0;
`endif
        if (s > 2047) s = 2047;
        if (s < -2048) s = -2048;
        return s;
    endfunction

    function automatic int win(input int pix[NPIX], input int r, input int c, input int bias);
        int m;
        m = xform(pix[(r-1)*W + c-1], bias);
        if (xform(pix[(r-1)*W + c], bias) > m) m = xform(pix[(r-1)*W + c], bias);
        if (xform(pix[r*W + c-1], bias) > m)   m = xform(pix[r*W + c-1], bias);
        if (xform(pix[r*W + c], bias) > m)     m = xform(pix[r*W + c], bias);
        return m;
    endfunction

    // Send the first n pixels of a frame with 0..maxgap idle cycles before each.
    // Every completed 2x2 window queues its expected output, due one cycle after
    // its bottom-right pixel is accepted.
    task automatic send(input int pix[NPIX], input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            int gap;
            int r;
            int c;
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (gap) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            r = i / W;
            c = i % W;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                exp_t e;
                e.fd  = (i == NPIX - 1);
                e.cyc = cyc + 1;
                e.val = win(pix, r, c, BIAS_A);
                q_a.push_back(e);
                e.val = win(pix, r, c, BIAS_B);
                q_b.push_back(e);
            end
            in_valid = 1'b1;
            in_data  = IN_W'(pix[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid_a", ov_a, 0);
        check("rst_out_data_a", od_a, 0);
        check("rst_frame_done_a", fd_a, 0);
        check("rst_out_valid_b", ov_b, 0);
        check("rst_out_data_b", od_b, 0);
        check("rst_frame_done_b", fd_b, 0);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_q_a", q_a.size(), 0);
        check("drain_q_b", q_b.size(), 0);
    endtask

    // Monitors
    always @(negedge clk) begin
        if (!rst) begin
            if (ov_a) begin
                if (q_a.size() == 0) begin
                    check("unexpected_out_a", 1, 0);
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    check("data_a", $signed(od_a), e.val);
                    check("frame_done_a", fd_a, e.fd);
                    check("latency_a", cyc, e.cyc);
                end
            end else if (fd_a) begin
                check("stray_frame_done_a", fd_a, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ov_b) begin
                if (q_b.size() == 0) begin
                    check("unexpected_out_b", 1, 0);
                end else begin
                    exp_t e;
                    e = q_b.pop_front();
                    check("data_b", $signed(od_b), e.val);
                    check("frame_done_b", fd_b, e.fd);
                    check("latency_b", cyc, e.cyc);
                end
            end else if (fd_b) begin
                check("stray_frame_done_b", fd_b, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete, got %0d errors in %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        int ramp[NPIX];
        int ramp2[NPIX];
        int pix[NPIX];

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        for (int i = 0; i < NPIX; i++) begin
            ramp[i]  = i;
            ramp2[i] = i + 200;
        end

        @(negedge clk);
        do_reset();

        // Ramp frame, no gaps
        send(ramp, NPIX, 0);
        drain();

        // Uniform negative frame
        for (int i = 0; i < NPIX; i++) pix[i] = -100;
        send(pix, NPIX, 0);
        drain();

        // Saturation: 8191 in even-numbered window columns, rest -8192
        for (int i = 0; i < NPIX; i++) begin
            pix[i] = (((i / W) % 2 == 0) && ((i % W) % 4 == 0)) ? 8191 : -8192;
        end
        send(pix, NPIX, 0);
        drain();

        // Gapped ramp frame
        send(ramp, NPIX, 5);
        drain();

        // Partial frame (37 pixels), then reset mid-frame, then a clean ramp
        send(ramp, 37, 1);
        repeat (3) @(negedge clk);
        drain();
        do_reset();
        send(ramp, NPIX, 0);
        drain();

        // Back-to-back frames, second offset by +200
        send(ramp, NPIX, 0);
        send(ramp2, NPIX, 0);
        drain();

        // Random frames across the full input range, short random gaps, back-to-back
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NPIX; i++) begin
                pix[i] = int'($urandom_range(16383, 0)) - 8192;
            end
            send(pix, NPIX, (f % 2 == 0) ? 0 : 2);
        end
        drain();

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
